// File: rtl/ip_vdp_write_fifo.sv
// ip_vdp_write_fifo: posted-write FIFO between the CPU bus and the VDP port.
// Writes are queued and drained to the VDP in order. A read first waits for
// every queued write to leave, then issues a single VDP read and returns the
// data with a one-cycle bus_rdata_en strobe.
// Optional build macro IP_VDP_WRITE_FIFO_LEVEL_EN adds the fifo_level and
// fifo_peak occupancy outputs.
module ip_vdp_write_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU side
    input  logic [1:0]            bus_address,
    input  logic                  bus_ioreq,
    input  logic                  bus_write,
    input  logic                  bus_valid,
    output logic                  bus_ready,
    input  logic [7:0]            bus_wdata,
    output logic [7:0]            bus_rdata,
    output logic                  bus_rdata_en,
    // VDP side
    output logic [1:0]            vdp_address,
    output logic                  vdp_ioreq,
    output logic                  vdp_write,
    output logic                  vdp_valid,
    input  logic                  vdp_ready,
    output logic [7:0]            vdp_wdata,
    input  logic [7:0]            vdp_rdata,
`ifdef IP_VDP_WRITE_FIFO_LEVEL_EN
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [DEPTH_LOG2:0]   fifo_peak,
`endif
    input  logic                  vdp_rdata_en
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } fifo_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        RD_REQ,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    fifo_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;

    logic [1:0]  r_rd_addr;
    logic [7:0]  r_bus_rdata;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_rd_latch;
    logic        w_rd_capture;
    fifo_entry_t w_head;
    fifo_entry_t w_new_entry;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_new_entry = '{addr: bus_address, data: bus_wdata};

    assign vdp_ioreq   = vdp_valid;
    assign bus_rdata   = r_bus_rdata;

    // Next state, handshakes and VDP-side request muxing
    always_comb begin
        w_state_nxt  = r_state;
        bus_ready    = 1'b0;
        bus_rdata_en = 1'b0;
        vdp_valid    = 1'b0;
        vdp_write    = 1'b1;
        vdp_address  = w_head.addr;
        vdp_wdata    = w_head.data;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_rd_latch   = 1'b0;
        w_rd_capture = 1'b0;

        case (r_state)
            IDLE: begin
                bus_ready = !w_full;
                vdp_valid = !w_empty;
                w_pop     = !w_empty && vdp_ready;
                // Acceptance is re-derived here rather than read back from bus_ready
                if (bus_valid && bus_ioreq && !w_full) begin
                    if (bus_write) begin
                        w_push = 1'b1;
                    end else begin
                        w_rd_latch  = 1'b1;
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                vdp_valid = !w_empty;
                w_pop     = !w_empty && vdp_ready;
                // Leave only once the count has been observed at zero
                if (w_empty) begin
                    w_state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                vdp_valid   = 1'b1;
                vdp_write   = 1'b0;
                vdp_address = r_rd_addr;
                vdp_wdata   = 8'h00;
                if (vdp_ready) begin
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (vdp_rdata_en) begin
                    w_rd_capture = 1'b1;
                    w_state_nxt  = RD_RESP;
                end
            end
            RD_RESP: begin
                bus_rdata_en = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO pointers and count; reset discards queued writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // FIFO storage (no reset needed, validity tracked by the count)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new_entry;
        end
    end

    // Read address latch and read data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_addr   <= 2'b00;
            r_bus_rdata <= 8'h00;
        end else begin
            if (w_rd_latch) begin
                r_rd_addr <= bus_address;
            end
            if (w_rd_capture) begin
                r_bus_rdata <= vdp_rdata;
            end
        end
    end

`ifdef IP_VDP_WRITE_FIFO_LEVEL_EN
    logic [CW-1:0] r_peak;

    assign fifo_level = r_count;
    assign fifo_peak  = r_peak;

    // Sticky high-water mark, tracks the count in the same cycle it is reached
    always_ff @(posedge clk) begin
        if (reset) begin
            r_peak <= '0;
        end else if (w_count_nxt > r_peak) begin
            r_peak <= w_count_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ip_vdp_write_fifo.sv
// Bench for ip_vdp_write_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ip_vdp_write_fifo;

    localparam int unsigned DL2   = 3;
    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] bus_address = 2'b00;
    logic       bus_ioreq = 1'b0;
    logic       bus_write = 1'b0;
    logic       bus_valid = 1'b0;
    logic       bus_ready;
    logic [7:0] bus_wdata = 8'h00;
    logic [7:0] bus_rdata;
    logic       bus_rdata_en;
    logic [1:0] vdp_address;
    logic       vdp_ioreq;
    logic       vdp_write;
    logic       vdp_valid;
    logic       vdp_ready = 1'b0;
    logic [7:0] vdp_wdata;
    logic [7:0] vdp_rdata = 8'h00;
    logic       resp_en = 1'b0;
    logic       stray_en = 1'b0;
    wire        w_rdata_en = resp_en | stray_en;
`ifdef IP_VDP_WRITE_FIFO_LEVEL_EN
    logic [DL2:0] fifo_level;
    logic [DL2:0] fifo_peak;
`endif

    ip_vdp_write_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_address  (bus_address),
        .bus_ioreq    (bus_ioreq),
        .bus_write    (bus_write),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_rdata_en (bus_rdata_en),
        .vdp_address  (vdp_address),
        .vdp_ioreq    (vdp_ioreq),
        .vdp_write    (vdp_write),
        .vdp_valid    (vdp_valid),
        .vdp_ready    (vdp_ready),
        .vdp_wdata    (vdp_wdata),
        .vdp_rdata    (vdp_rdata),
`ifdef IP_VDP_WRITE_FIFO_LEVEL_EN
        .fifo_level   (fifo_level),
        .fifo_peak    (fifo_peak),
`endif
        .vdp_rdata_en (w_rdata_en)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] a;
        logic [7:0] d;
    } ent_t;

    ent_t       mq[$];
    bit         m_on      = 1'b0;
    bit         rd_pend   = 1'b0;
    bit         rd_issued = 1'b0;
    bit         rd_resp   = 1'b0;
    logic [1:0] rd_addr   = 2'b00;
    logic [7:0] last_rdata = 8'h00;
`ifdef IP_VDP_WRITE_FIFO_LEVEL_EN
    int         m_peak = 0;
`endif

    // observation logs used by the directed scenarios
    ent_t wr_log[$];
    int   wr_log_cyc[$];
    int   rd_log_cyc[$];
    int   acc_cyc[$];
    int   pulse_cnt = 0;

    // Compare DUT against the model, then advance the model past the coming edge
    always @(negedge clk) begin : mon
        bit exp_ready;
        bit rsp_now;
        exp_ready = !rd_pend && (mq.size() < DEPTH);
        if (bus_rdata_en === 1'b1) pulse_cnt++;
        if (m_on) begin
            chk("bus_ready", {31'd0, bus_ready}, {31'd0, exp_ready});
            chk("vdp_ioreq", {31'd0, vdp_ioreq}, {31'd0, vdp_valid});
            if (mq.size() > 0) begin
                chk("vdp_valid_wr", {31'd0, vdp_valid}, 32'd1);
                chk("vdp_write_wr", {31'd0, vdp_write}, 32'd1);
                chk("vdp_address_wr", {30'd0, vdp_address}, {30'd0, mq[0].a});
                chk("vdp_wdata_wr", {24'd0, vdp_wdata}, {24'd0, mq[0].d});
            end else if (!rd_pend) begin
                chk("vdp_valid_idle", {31'd0, vdp_valid}, 32'd0);
            end
            if (vdp_valid === 1'b1 && vdp_write === 1'b0) begin
                chk("rd_fifo_empty", mq.size(), 32'd0);
                chk("rd_outstanding", {31'd0, rd_pend && !rd_issued}, 32'd1);
                chk("rd_address", {30'd0, vdp_address}, {30'd0, rd_addr});
            end
            chk("bus_rdata_en", {31'd0, bus_rdata_en}, {31'd0, rd_resp});
            chk("bus_rdata", {24'd0, bus_rdata}, {24'd0, last_rdata});
`ifdef IP_VDP_WRITE_FIFO_LEVEL_EN
            chk("fifo_level", {28'd0, fifo_level}, mq.size());
            chk("fifo_peak", {28'd0, fifo_peak}, m_peak);
`endif
        end
        if (reset) begin
            mq.delete();
            rd_pend    = 1'b0;
            rd_issued  = 1'b0;
            rd_resp    = 1'b0;
            last_rdata = 8'h00;
`ifdef IP_VDP_WRITE_FIFO_LEVEL_EN
            m_peak = 0;
`endif
            m_on = 1'b1;
        end else if (m_on) begin
            rsp_now = rd_resp;
            if (rd_issued && !rd_resp && w_rdata_en) begin
                rd_resp    = 1'b1;
                last_rdata = vdp_rdata;
            end
            if (rsp_now) begin
                rd_pend   = 1'b0;
                rd_issued = 1'b0;
                rd_resp   = 1'b0;
            end
            if (vdp_valid === 1'b1 && vdp_ready) begin
                if (vdp_write) begin
                    wr_log.push_back({vdp_address, vdp_wdata});
                    wr_log_cyc.push_back(cyc);
                    if (mq.size() > 0) begin
                        void'(mq.pop_front());
                    end else begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL vdp_write_from_empty: got addr 0x%0h data 0x%0h, expected no write", vdp_address, vdp_wdata);
                    end
                end else begin
                    rd_issued = 1'b1;
                    rd_log_cyc.push_back(cyc);
                end
            end
            if (bus_valid && bus_ioreq && exp_ready) begin
                acc_cyc.push_back(cyc);
                if (bus_write) begin
                    mq.push_back({bus_address, bus_wdata});
                end else begin
                    rd_pend = 1'b1;
                    rd_addr = bus_address;
                end
            end
`ifdef IP_VDP_WRITE_FIFO_LEVEL_EN
            if (mq.size() > m_peak) m_peak = mq.size();
`endif
        end
    end

    // ---------------- VDP read responder ----------------
    logic [7:0] resp_data  = 8'h00;
    int         resp_delay = 1;
    bit         resp_on    = 1'b1;

    always @(negedge clk) begin
        if (resp_on && !reset && vdp_valid === 1'b1 && vdp_write === 1'b0 && vdp_ready) begin
            repeat (resp_delay) @(posedge clk);
            #1;
            resp_en   = 1'b1;
            vdp_rdata = resp_data;
            @(posedge clk);
            #1;
            resp_en   = 1'b0;
            vdp_rdata = 8'h00;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        bus_valid = 1'b0;
        bus_ioreq = 1'b0;
    endtask

    task automatic attempt(input bit wr, input bit io, input logic [1:0] a,
                           input logic [7:0] d, output bit acc);
        bus_valid   = 1'b1;
        bus_ioreq   = io;
        bus_write   = wr;
        bus_address = a;
        bus_wdata   = d;
        @(negedge clk);
        acc = (bus_ready === 1'b1) && io;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            attempt(1'b1, 1'b1, a, d, acc);
            tries++;
        end
        chk("write_accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_log_cyc.delete();
        rd_log_cyc.delete();
        acc_cyc.delete();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : main
        bit acc;
        bit last;
        int n_acc;
        int p0;
        int guard;

        step(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_bus_ready", {31'd0, bus_ready}, 32'd1);
        chk("rst_vdp_valid", {31'd0, vdp_valid}, 32'd0);
        chk("rst_bus_rdata", {24'd0, bus_rdata}, 32'h00);
        chk("rst_bus_rdata_en", {31'd0, bus_rdata_en}, 32'd0);
        @(posedge clk);
        #1;

        // three writes streamed straight through
        clear_logs();
        vdp_ready = 1'b1;
        wr(2'd1, 8'h12);
        wr(2'd1, 8'h87);
        wr(2'd1, 8'h34);
        idle();
        step(6);
        chk("t1_count", wr_log.size(), 32'd3);
        if (wr_log.size() == 3 && acc_cyc.size() == 3) begin
            chk("t1_d0", {24'd0, wr_log[0].d}, 32'h12);
            chk("t1_d1", {24'd0, wr_log[1].d}, 32'h87);
            chk("t1_d2", {24'd0, wr_log[2].d}, 32'h34);
            chk("t1_a0", {30'd0, wr_log[0].a}, 32'd1);
            chk("t1_a2", {30'd0, wr_log[2].a}, 32'd1);
            chk("t1_latency", wr_log_cyc[0] - acc_cyc[0], 32'd1);
        end

        // fill to full with the VDP stalled
        clear_logs();
        vdp_ready = 1'b0;
        n_acc = 0;
        last  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            attempt(1'b1, 1'b1, 2'd2, 8'(8'h40 + i), acc);
            if (i < 8) n_acc += int'(acc);
            else       last = acc;
        end
        idle();
        chk("t2_accepted", n_acc, 32'd8);
        chk("t2_ninth_rejected", {31'd0, last}, 32'd0);
        @(negedge clk);
        chk("t2_full_not_ready", {31'd0, bus_ready}, 32'd0);
        @(posedge clk);
        #1;
        vdp_ready = 1'b1;
        step(1);
        vdp_ready = 1'b0;
        @(negedge clk);
        chk("t2_ready_after_pop", {31'd0, bus_ready}, 32'd1);
        @(posedge clk);
        #1;
        vdp_ready = 1'b1;
        step(10);
        vdp_ready = 1'b0;
        chk("t2_drained", wr_log.size(), 32'd8);
        if (wr_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t2_order", {24'd0, wr_log[i].d}, 32'h40 + i);
            end
        end

        // read behind two queued writes
        clear_logs();
        p0 = pulse_cnt;
        wr(2'd1, 8'h11);
        wr(2'd2, 8'h22);
        attempt(1'b0, 1'b1, 2'd1, 8'h00, acc);
        idle();
        chk("t3_read_accepted", {31'd0, acc}, 32'd1);
        resp_data  = 8'hA5;
        resp_delay = 2;
        step(4);
        chk("t3_no_early_read", rd_log_cyc.size(), 32'd0);
        vdp_ready = 1'b1;
        guard = 0;
        while (pulse_cnt == p0 && guard < 40) begin
            step(1);
            guard++;
        end
        step(3);
        vdp_ready = 1'b0;
        chk("t3_pulse_count", pulse_cnt - p0, 32'd1);
        chk("t3_rdata", {24'd0, bus_rdata}, 32'hA5);
        chk("t3_writes_first", wr_log.size(), 32'd2);
        chk("t3_one_read", rd_log_cyc.size(), 32'd1);
        if (wr_log.size() == 2 && rd_log_cyc.size() == 1) begin
            chk("t3_read_after_writes", {31'd0, rd_log_cyc[0] > wr_log_cyc[1]}, 32'd1);
        end

        // push and pop together at count 4
        clear_logs();
        for (int i = 0; i < 4; i++) wr(2'd3, 8'(8'hA0 + i));
        vdp_ready = 1'b1;
        attempt(1'b1, 1'b1, 2'd3, 8'hA4, acc);
        vdp_ready = 1'b0;
        idle();
        chk("t4_simul_accept", {31'd0, acc}, 32'd1);
        chk("t4_simul_popped", wr_log.size(), 32'd1);
`ifdef IP_VDP_WRITE_FIFO_LEVEL_EN
        @(negedge clk);
        chk("t4_level_4", {28'd0, fifo_level}, 32'd4);
        @(posedge clk);
        #1;
`endif
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            attempt(1'b1, 1'b1, 2'd3, 8'(8'hA5 + i), acc);
            n_acc += int'(acc);
        end
        attempt(1'b1, 1'b1, 2'd3, 8'hA9, last);
        idle();
        chk("t4_room_for_4", n_acc, 32'd4);
        chk("t4_then_full", {31'd0, last}, 32'd0);
        vdp_ready = 1'b1;
        step(12);
        chk("t4_total", wr_log.size(), 32'd9);
        if (wr_log.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                chk("t4_order", {24'd0, wr_log[i].d}, 32'hA0 + i);
            end
        end

        // request without ioreq is ignored
        clear_logs();
        attempt(1'b1, 1'b0, 2'd0, 8'h55, acc);
        idle();
        step(3);
        chk("ioreq_ignored", wr_log.size(), 32'd0);

        // reset while waiting for read data
        clear_logs();
        resp_on = 1'b0;
        p0 = pulse_cnt;
        attempt(1'b0, 1'b1, 2'd2, 8'h00, acc);
        idle();
        guard = 0;
        while (rd_log_cyc.size() == 0 && guard < 20) begin
            step(1);
            guard++;
        end
        chk("t5_read_issued", rd_log_cyc.size(), 32'd1);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_vdp_valid", {31'd0, vdp_valid}, 32'd0);
        chk("t5_vdp_ioreq", {31'd0, vdp_ioreq}, 32'd0);
        chk("t5_bus_ready", {31'd0, bus_ready}, 32'd1);
        @(posedge clk);
        #1;
        step(6);
        stray_en = 1'b1;
        step(1);
        stray_en = 1'b0;
        step(3);
        chk("t5_no_rdata_en", pulse_cnt - p0, 32'd0);
        resp_on = 1'b1;

`ifdef IP_VDP_WRITE_FIFO_LEVEL_EN
        // occupancy high-water mark
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        vdp_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(2'd0, 8'(8'h60 + i));
        idle();
        @(negedge clk);
        chk("t6_level_5", {28'd0, fifo_level}, 32'd5);
        chk("t6_peak_5", {28'd0, fifo_peak}, 32'd5);
        @(posedge clk);
        #1;
        vdp_ready = 1'b1;
        step(8);
        @(negedge clk);
        chk("t6_level_0", {28'd0, fifo_level}, 32'd0);
        chk("t6_peak_sticky", {28'd0, fifo_peak}, 32'd5);
        @(posedge clk);
        #1;
`endif

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop if the scenario sequence ever stalls
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got no completion by cycle %0d, expected finish earlier", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
